// File: rtl/mux_scan_ctrl_pkg.sv
// rtl/mux_scan_ctrl_pkg.sv - shared state encodings and widths for the mux scan sequencer
package mux_scan_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CH_W    = 2;
  localparam int FRAME_W = 4;
  localparam int CNT_W   = 8;

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// rtl/mux_scan_ctrl_settle_timer.sv - per-channel settle counter, ticks on the last settle cycle
module mux_scan_ctrl_settle_timer
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // Reload to zero on the tick so the next channel gets a full settle window
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - select-side sequencer for a 4:1 mux, packing four samples into a frame
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE     = 1,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mux_out,
  output logic               sel1,
  output logic               sel0,
  output logic               busy,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [CNT_W-1:0]   frame_cnt
);

  logic [1:0]         state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CH_W-1:0]    sel_q, sel_d;
  logic [FRAME_W-2:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               tick;
  logic               timer_en;
  logic               timer_clr;

  assign timer_en  = (state_q == S_SCAN);
  assign timer_clr = ~timer_en;

  mux_scan_ctrl_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clr),
    .enable(timer_en),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    shadow_d    = shadow_q;
    frame_d     = frame_q;
    valid_d     = valid_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = S_SCAN;
          ch_d    = '0;
        end
      end
      S_SCAN: begin
        if (tick) begin
          case (ch_q)
            2'd0: shadow_d[0] = mux_out;
            2'd1: shadow_d[1] = mux_out;
            2'd2: shadow_d[2] = mux_out;
            default: begin
              frame_d = {mux_out, shadow_q};
              valid_d = 1'b1;
              state_d = S_DONE;
            end
          endcase
          // Channel 3 wraps back to 0 for the next scan
          ch_d = ch_q + 1'b1;
        end
      end
      S_DONE: begin
        if (frame_ready) begin
          valid_d     = 1'b0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          ch_d        = '0;
          state_d     = CONTINUOUS ? S_SCAN : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = '0;
        valid_d = 1'b0;
      end
    endcase
    // Outputs are derived from next state so they leave the flops already aligned
    busy_d = (state_d == S_SCAN) || (state_d == S_DONE);
    sel_d  = (state_d == S_SCAN) ? ch_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      sel_q       <= '0;
      shadow_q    <= '0;
      frame_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sel1        = sel_q[1];
  assign sel0        = sel_q[0];
  assign busy        = busy_q;
  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl driving two inline 4:1 muxes
module tb_mux_scan_ctrl;

  localparam int SA = 3;
  localparam int SB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, start_a, start_b, ready_a, ready_b;
  logic [3:0] in_bus;
  logic       mux_a, mux_b;
  logic       sel1_a, sel0_a, sel1_b, sel0_b;
  logic       busy_a, busy_b, fv_a, fv_b;
  logic [3:0] frame_a, frame_b;
  logic [7:0] cnt_a, cnt_b;

  assign mux_a = in_bus[{sel1_a, sel0_a}];
  assign mux_b = in_bus[{sel1_b, sel0_b}];

  mux_scan_ctrl #(.SETTLE(SA), .CONTINUOUS(1'b0)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .mux_out(mux_a),
    .sel1(sel1_a), .sel0(sel0_a), .busy(busy_a), .frame(frame_a),
    .frame_valid(fv_a), .frame_ready(ready_a), .frame_cnt(cnt_a)
  );

  mux_scan_ctrl #(.SETTLE(SB), .CONTINUOUS(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .mux_out(mux_b),
    .sel1(sel1_b), .sel0(sel0_b), .busy(busy_b), .frame(frame_b),
    .frame_valid(fv_b), .frame_ready(ready_b), .frame_cnt(cnt_b)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  logic [3:0] hist [0:16383];
  logic [3:0] qa[$];
  logic [3:0] qb[$];

  // hist[k] is the mux input vector present at rising edge k
  always @(posedge clk) begin
    hist[edge_n] <= in_bus;
    edge_n       <= edge_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Bit k of a frame is input k as seen at the (k+1)-th settle boundary after the scan start edge
  function automatic logic [3:0] exp_frame(input int s, input int settle);
    logic [3:0] f;
    logic [3:0] v;
    for (int k = 0; k < 4; k++) begin
      v    = hist[s + (k + 1) * settle];
      f[k] = v[k];
    end
    return f;
  endfunction

  int         exp_cnt_a = 0;
  int         exp_cnt_b = 0;
  bit         chk_cnt_a = 1'b0;
  bit         chk_cnt_b = 1'b0;
  bit         b_active  = 1'b0;
  int         busy_drops = 0;
  logic [3:0] pop_a, pop_b;

  always @(negedge clk) begin
    #4;
    if (chk_cnt_a) begin
      check("frame_cnt_a", 32'(cnt_a), 32'(exp_cnt_a));
      chk_cnt_a = 1'b0;
    end
    if (rst_a) begin
      exp_cnt_a = 0;
    end else if (fv_a && ready_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_a act=%b exp=none", frame_a);
      end else begin
        pop_a = qa.pop_front();
        check("frame_a", 32'(frame_a), 32'(pop_a));
      end
      exp_cnt_a = (exp_cnt_a + 1) % 256;
      chk_cnt_a = 1'b1;
    end
  end

  always @(negedge clk) begin
    #4;
    if (b_active && !busy_b) busy_drops++;
    if (chk_cnt_b) begin
      check("frame_cnt_b", 32'(cnt_b), 32'(exp_cnt_b));
      chk_cnt_b = 1'b0;
    end
    if (rst_b) begin
      exp_cnt_b = 0;
    end else if (fv_b && ready_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_b act=%b exp=none", frame_b);
      end else begin
        pop_b = qb.pop_front();
        check("frame_b", 32'(frame_b), 32'(pop_b));
      end
      exp_cnt_b = (exp_cnt_b + 1) % 256;
      chk_cnt_b = 1'b1;
    end
  end

  task automatic run_a(input int stall, input bit do_rst);
    int         e;
    int         bad;
    bit         acc;
    logic [3:0] ef;
    @(negedge clk);
    start_a = 1'b1;
    in_bus  = 4'($urandom);
    e       = edge_n;
    bad     = 0;
    acc     = 1'b0;
    ef      = '0;
    if (do_rst) begin
      ready_a = 1'b0;
      while (edge_n < e + 3 * SA) begin
        @(negedge clk);
        start_a = 1'b0;
        in_bus  = 4'($urandom);
      end
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      check("rst_outputs_a", 32'({sel1_a, sel0_a, busy_a, frame_a, fv_a, cnt_a}), 32'd0);
      repeat (4 * SA + 4) begin
        @(negedge clk);
        if (fv_a) bad++;
      end
      check("no_valid_after_rst", 32'(bad), 32'd0);
      return;
    end
    while (!acc) begin
      @(negedge clk);
      start_a = ($urandom_range(0, 3) == 0);
      in_bus  = 4'($urandom);
      if (edge_n == e + 4 * SA) check("latency_pre_a", 32'(fv_a), 32'd0);
      if (edge_n == e + 4 * SA + 1) begin
        check("latency_a", 32'(fv_a), 32'd1);
        ef = exp_frame(e, SA);
        qa.push_back(ef);
      end
      if (edge_n >= e + 4 * SA + 1) begin
        if ({sel1_a, sel0_a, busy_a, fv_a, frame_a} != {2'b00, 1'b1, 1'b1, ef}) bad++;
        ready_a = (edge_n >= e + 4 * SA + 1 + stall);
        acc     = ready_a;
      end else begin
        ready_a = 1'($urandom);
      end
    end
    check("done_hold_a", 32'(bad), 32'd0);
    @(negedge clk);
    start_a = 1'b0;
    ready_a = 1'b0;
    check("idle_after_accept_a", 32'({busy_a, fv_a, sel1_a, sel0_a}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  int  e_b, cur, frames;
  bit  pushed, c300;

  initial begin
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    in_bus  = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_a", 32'({sel1_a, sel0_a, busy_a, frame_a, fv_a, cnt_a}), 32'd0);
    check("reset_b", 32'({sel1_b, sel0_b, busy_b, frame_b, fv_b, cnt_b}), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    run_a(0, 1'b0);
    run_a(10, 1'b0);
    run_a(0, 1'b1);
    run_a(2, 1'b0);

    // Corrupt the state register mid-scan; the next edge must land in IDLE
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    check("scan_before_force", 32'(busy_a), 32'd1);
    force u_a.state_q = 2'd3;
    #1;
    release u_a.state_q;
    @(negedge clk);
    check("illegal_state_recover", 32'({busy_a, sel1_a, sel0_a, fv_a}), 32'd0);
    run_a(1, 1'b0);

    for (int i = 0; i < 25; i++) run_a($urandom_range(0, 4), 1'b0);

    @(negedge clk);
    start_b = 1'b1;
    in_bus  = 4'b1101;
    e_b     = edge_n;
    cur     = e_b;
    frames  = 0;
    pushed  = 1'b0;
    c300    = 1'b0;
    while (frames < 340) begin
      @(negedge clk);
      start_b  = 1'b0;
      b_active = 1'b1;
      if (frames == 0) begin
        if (edge_n - 1 >= e_b && edge_n - 1 <= e_b + 3)
          check("sel_sequence_b", 32'({sel1_b, sel0_b}), 32'(edge_n - 1 - e_b));
        if (edge_n == e_b + 4 * SB) check("latency_pre_b", 32'(fv_b), 32'd0);
        if (edge_n == e_b + 4 * SB + 1) begin
          check("latency_b", 32'(fv_b), 32'd1);
          check("frame_1101", 32'(frame_b), 32'b1101);
        end
      end
      if (frames == 300 && !c300) begin
        check("cnt_wrap_44", 32'(cnt_b), 32'd44);
        c300 = 1'b1;
      end
      if (!pushed && edge_n > cur + 4 * SB) begin
        qb.push_back(exp_frame(cur, SB));
        pushed = 1'b1;
      end
      in_bus  = (frames == 0) ? 4'b1101 : 4'($urandom);
      ready_b = (frames < 300) ? 1'b1 : 1'($urandom);
      if (ready_b && edge_n >= cur + 4 * SB + 1) begin
        frames++;
        cur    = edge_n;
        pushed = 1'b0;
      end
    end
    @(negedge clk);
    ready_b = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_continuous_b", 32'(busy_drops), 32'd0);
    check("queue_a_drained", 32'(qa.size()), 32'd0);
    check("queue_b_drained", 32'(qb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
